// File: rtl/sprite_position_controller_if.sv
// Signal bundle between the SNES reader / VGA renderer side and the sprite position controller.
// Port names stay those of the surrounding system, so the bus needs no renaming at either end.
interface sprite_position_controller_if;
    logic       frame_tick;
    logic       up_n;
    logic       down_n;
    logic       left_n;
    logic       right_n;
    logic       home_n;
    logic       wrap_en;
    logic [9:0] col;
    logic [9:0] row;
    logic       moving;
    logic [3:0] at_edge;

    modport master (
        output frame_tick, up_n, down_n, left_n, right_n, home_n, wrap_en,
        input  col, row, moving, at_edge
    );

    modport slave (
        input  frame_tick, up_n, down_n, left_n, right_n, home_n, wrap_en,
        output col, row, moving, at_edge
    );
endinterface

// File: rtl/sprite_position_controller.sv
// Frame-paced sprite position register: D-pad press/hold auto-repeat, diagonal motion,
// clamp or wrap at the screen edges, and a home button that recenters the sprite.
module sprite_position_controller #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int SPR_W        = 16,
    parameter int SPR_H        = 16,
    parameter int STEP         = 16,
    parameter int REPEAT_DELAY = 15,
    parameter int REPEAT_RATE  = 4,
    parameter int X0           = (H_RES - SPR_W) / 2,
    parameter int Y0           = (V_RES - SPR_H) / 2
) (
    input  logic                          clk,
    input  logic                          reset,
    sprite_position_controller_if.slave   bus
);

    localparam logic [9:0] X_MAX  = 10'(H_RES - SPR_W);
    localparam logic [9:0] Y_MAX  = 10'(V_RES - SPR_H);
    localparam logic [9:0] STEP_V = 10'(STEP);
    localparam logic [9:0] X0_V   = 10'(X0);
    localparam logic [9:0] Y0_V   = 10'(Y0);

    localparam int CNT_TOP = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = (CNT_TOP > 1) ? $clog2(CNT_TOP) : 1;
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_e;

    // Direction after cancelling opposite buttons; all-zero means "released".
    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } dir_t;

    state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dir_t       vec_q, vec_d;
    dir_t       vec;
    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;
    logic       do_step;

    function automatic logic [9:0] step_axis(input logic [9:0] pos, input logic dec,
                                             input logic inc, input logic [9:0] max_v,
                                             input logic wrap);
        logic [9:0] res;
        res = pos;
        if (dec) begin
            if (wrap && pos == '0)      res = max_v;
            else if (pos < STEP_V)      res = '0;
            else                        res = pos - STEP_V;
        end else if (inc) begin
            if (wrap && pos == max_v)   res = '0;
            else if (pos > max_v - STEP_V) res = max_v;
            else                        res = pos + STEP_V;
        end
        return res;
    endfunction

    always_comb begin
        vec.up    = ~bus.up_n    &  bus.down_n;
        vec.down  = ~bus.down_n  &  bus.up_n;
        vec.left  = ~bus.left_n  &  bus.right_n;
        vec.right = ~bus.right_n &  bus.left_n;
    end

    // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        col_d   = col_q;
        row_d   = row_q;
        do_step = 1'b0;

        if (bus.frame_tick) begin
            if (!bus.home_n) begin
                col_d   = X0_V;
                row_d   = Y0_V;
                state_d = IDLE;
                cnt_d   = '0;
            end else if (vec == '0) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (state_q == IDLE || vec != vec_q) begin
                do_step = 1'b1;
                vec_d   = vec;
                state_d = HOLD;
                cnt_d   = '0;
            end else if (state_q == HOLD) begin
                if (cnt_q == DELAY_LAST) begin
                    do_step = 1'b1;
                    state_d = REPEAT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                if (cnt_q == RATE_LAST) begin
                    do_step = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        if (do_step) begin
            col_d = step_axis(col_q, vec.left, vec.right, X_MAX, bus.wrap_en);
            row_d = step_axis(row_q, vec.up,   vec.down,  Y_MAX, bus.wrap_en);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            col_q   <= X0_V;
            row_q   <= Y0_V;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    assign bus.col     = col_q;
    assign bus.row     = row_q;
    assign bus.moving  = (state_q != IDLE);
    assign bus.at_edge = {row_q == '0, row_q == Y_MAX, col_q == '0, col_q == X_MAX};

endmodule
